// File: rtl/mw_alu_sequencer.sv
// Multi-word ALU sequencer: streams operand word pairs through the shared
// 16-bit ALU, chaining E from word to word, and reports final E/Z/N/OVF flags.
module mw_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_ac,
  output logic [WIDTH-1:0] alu_dr,
  output logic             alu_e,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_co,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_last,
  output logic             done,
  output logic             flag_e,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_ovf,
  output logic             flag_err,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data holds while valid && !ready.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  state_t           state, state_nx;
  logic             rdy_en;
  logic [2:0]       op_reg;
  logic [LEN_W-1:0] remaining;
  logic             e_reg;
  logic             z_acc;
  logic             ovf_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cmd_bad;
  logic             chains_e;

  assign cmd_bad   = (cmd_op == 3'b000) || (cmd_op == 3'b111) || (cmd_len == '0);
  assign chains_e  = (op_reg == OP_ADD) || (op_reg == OP_SHR) || (op_reg == OP_SHL);
  assign alu_ac    = a_reg;
  assign alu_dr    = b_reg;
  assign alu_e     = e_reg;
  assign dbg_state = state;

  always_comb begin
    state_nx  = state;
    // rdy_en keeps cmd_ready low through reset and rises one cycle after release
    cmd_ready = (state == S_IDLE) && rdy_en;
    in_ready  = (state == S_FETCH);
    out_valid = (state == S_EMIT);
    out_last  = (state == S_EMIT) && (remaining == LEN_W'(1));
    done      = (state == S_DONE);
    busy      = (state != S_IDLE);
    alu_op    = (state == S_EXEC) ? op_reg : 3'b000;
    case (state)
      S_IDLE:  if (cmd_valid && cmd_ready) state_nx = cmd_bad ? S_DONE : S_FETCH;
      S_FETCH: if (in_valid) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_EMIT;
      S_EMIT:  if (out_ready) state_nx = (remaining == LEN_W'(1)) ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdy_en    <= 1'b0;
      op_reg    <= '0;
      remaining <= '0;
      e_reg     <= 1'b0;
      z_acc     <= 1'b0;
      ovf_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_word  <= '0;
      flag_e    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_reg    <= cmd_op;
            remaining <= cmd_len;
            e_reg     <= cmd_cin;
            z_acc     <= 1'b1;
            ovf_reg   <= 1'b0;
            if (cmd_bad) begin
              flag_err <= 1'b1;
              flag_e   <= cmd_cin;
              flag_z   <= 1'b0;
              flag_n   <= 1'b0;
              flag_ovf <= 1'b0;
            end else begin
              flag_err <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
          end
        end
        S_EXEC: begin
          out_word <= alu_result;
          // Logic ops leave E alone; only add and shifts carry into the next word
          if (chains_e) e_reg <= alu_co;
          z_acc   <= z_acc & (alu_result == '0);
          ovf_reg <= (op_reg == OP_ADD) & alu_ovf;
        end
        S_EMIT: begin
          if (out_ready) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              flag_e   <= e_reg;
              flag_z   <= z_acc;
              flag_n   <= out_word[WIDTH-1];
              flag_ovf <= ovf_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mw_alu_sequencer.sv
// Bench for mw_alu_sequencer: a behavioural ALU, randomized commands and a
// whole-operand arithmetic reference model feeding an expected-word queue.
module tb_mw_alu_sequencer;

  localparam int W = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_cin;
  logic [2:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [W-1:0]  alu_ac, alu_dr, alu_result;
  logic          alu_e, alu_co, alu_ovf;
  logic [2:0]    alu_op;
  logic          out_valid, out_ready, out_last, done;
  logic [W-1:0]  out_word;
  logic          flag_e, flag_z, flag_n, flag_ovf, flag_err, busy;
  logic [2:0]    dbg_state;

  mw_alu_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_cin(cmd_cin),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_e(alu_e), .alu_op(alu_op),
    .alu_result(alu_result), .alu_co(alu_co), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .done(done),
    .flag_e(flag_e), .flag_z(flag_z), .flag_n(flag_n), .flag_ovf(flag_ovf),
    .flag_err(flag_err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Shared 16-bit ALU of the basic computer
  always_comb begin
    alu_result = '0;
    alu_co     = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_op)
      3'b001: begin
        {alu_co, alu_result} = {1'b0, alu_ac} + {1'b0, alu_dr} + {16'b0, alu_e};
        alu_ovf = (alu_ac[15] == alu_dr[15]) && (alu_result[15] != alu_ac[15]);
      end
      3'b010: alu_result = alu_ac & alu_dr;
      3'b011: alu_result = alu_dr;
      3'b100: alu_result = ~alu_ac;
      3'b101: begin alu_result = {alu_e, alu_ac[15:1]}; alu_co = alu_ac[0]; end
      3'b110: begin alu_result = {alu_ac[14:0], alu_e}; alu_co = alu_ac[15]; end
      default: ;
    endcase
  end

  // scoreboard
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] a_w[16];
  logic [W-1:0] b_w[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, cmd_ready, in_ready, alu_ac, alu_dr, alu_e, alu_op, out_valid,
            out_word, out_last, done, flag_e, flag_z, flag_n, flag_ovf, flag_err, busy};
  endfunction

  // Reference model over the whole multi-word operand; fills exp_q and flags.
  logic m_e, m_z, m_n, m_ovf, m_err;

  task automatic model(input logic [2:0] op, input int len, input logic cin);
    logic [255:0] a, b, r;
    logic [256:0] s, mask;
    int n, idx;
    a = '0; b = '0; r = '0;
    n = len * 16;
    m_err = (op == 3'b000) || (op == 3'b111) || (len == 0);
    m_e = cin; m_z = 1'b0; m_n = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    if (!m_err) begin
      mask = (257'(1) << n) - 257'(1);
      for (int i = 0; i < len; i++) begin
        idx = (op == 3'b101) ? len - 1 - i : i;
        a[idx*16 +: 16] = a_w[i];
        b[idx*16 +: 16] = b_w[i];
      end
      case (op)
        3'b001: begin
          s = {1'b0, a} + {1'b0, b} + 257'(cin);
          m_e = s[n];
          r = s[255:0] & mask[255:0];
          m_ovf = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]);
        end
        3'b010: r = a & b;
        3'b011: r = b;
        3'b100: r = ~a & mask[255:0];
        3'b101: begin r = (a >> 1) | (256'(cin) << (n - 1)); m_e = a[0]; end
        default: begin r = ((a << 1) | 256'(cin)) & mask[255:0]; m_e = a[n-1]; end
      endcase
      m_z = (r == '0);
      for (int i = 0; i < len; i++) begin
        idx = (op == 3'b101) ? len - 1 - i : i;
        exp_q.push_back(r[idx*16 +: 16]);
      end
      m_n = exp_q[len-1][15];
    end
  endtask

  // driver: mode 0 = no stalls, 1 = random stalls, 2 = hold out_ready low 5 cycles
  task automatic run_cmd(input logic [2:0] op, input int len, input logic cin, input int mode);
    int cyc, wi, stalls, hold, n, exp_words;
    model(op, len, cin);
    exp_words = m_err ? 0 : len;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len); cmd_cin = cin;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 2; wi = 0; stalls = 0; hold = (mode == 2) ? 5 : 0;
    while (!done && cyc < 400) begin
      check("cmd_ready_busy", cmd_ready, 0);
      check("in_out_excl", in_ready & out_valid, 0);
      check("alu_op", alu_op, (in_ready | out_valid) ? 3'b000 : op);
      in_valid = 1'b0; out_ready = 1'b0;
      if (mode == 1) cmd_valid = 1'($urandom_range(0, 1));
      if (in_ready) begin
        check("extra_fetch", wi < exp_words, 1);
        if (wi < 16 && (mode != 1 || $urandom_range(0, 9) < 7)) begin
          in_valid = 1'b1; in_a = a_w[wi]; in_b = b_w[wi]; wi++;
        end else stalls++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_extra", 1, 0);
        else begin
          check("out_word", out_word, exp_q[0]);
          check("out_last", out_last, exp_q.size() == 1);
          if (hold > 0) begin hold--; stalls++; end
          else if (mode == 1 && $urandom_range(0, 3) == 0) stalls++;
          else begin out_ready = 1'b1; void'(exp_q.pop_front()); end
        end
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("done_seen", done, 1);
    check("latency", cyc, m_err ? 2 : 2 + 3 * len + stalls);
    check("words_used", wi, exp_words);
    check("words_left", exp_q.size(), 0);
    check("flags", {flag_e, flag_z, flag_n, flag_ovf, flag_err}, {m_e, m_z, m_n, m_ovf, m_err});
    @(negedge clk);
    check("done_pulse", {done, cmd_ready}, 2'b01);
    check("flags_hold", {flag_e, flag_z, flag_n, flag_ovf, flag_err}, {m_e, m_z, m_n, m_ovf, m_err});
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_cin = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    // directed cases
    a_w[0] = 16'hFFFF; a_w[1] = 16'h0001; b_w[0] = 16'h0001; b_w[1] = 16'h0000;
    run_cmd(3'b001, 2, 1'b0, 0);
    a_w[0] = 16'h7FFF; b_w[0] = 16'h0001;
    run_cmd(3'b001, 1, 1'b0, 0);
    a_w[0] = 16'h8000; a_w[1] = 16'h0001; b_w[0] = 16'h1234; b_w[1] = 16'h5678;
    run_cmd(3'b110, 2, 1'b1, 0);
    a_w[0] = 16'h0001; a_w[1] = 16'h0000;
    run_cmd(3'b101, 2, 1'b0, 0);
    a_w[0] = 16'h1111; a_w[1] = 16'h2222; b_w[0] = 16'h3333; b_w[1] = 16'h4444;
    run_cmd(3'b011, 2, 1'b0, 2);
    run_cmd(3'b111, 2, 1'b1, 0);
    run_cmd(3'b001, 0, 1'b0, 0);

    // reset during word 2 of a 3-word AND
    a_w[0] = 16'hF0F0; b_w[0] = 16'hFF00;
    @(negedge clk);
    check("cmd_ready_pre_abort", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_len = 4'd3; cmd_cin = 1'b0;
    @(negedge clk); cmd_valid = 1'b0; in_valid = 1'b1; in_a = a_w[0]; in_b = b_w[0];
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("abort_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_recover", {cmd_ready, done, busy}, 3'b100);
    a_w[0] = 16'h00FF; b_w[0] = 16'h0F0F;
    run_cmd(3'b010, 1, 1'b0, 0);

    // randomized commands
    for (int t = 0; t < 30; t++) begin
      logic [2:0] op;
      int len;
      op  = 3'($urandom_range(0, 7));
      len = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
      for (int i = 0; i < 16; i++) begin
        a_w[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        b_w[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      end
      run_cmd(op, len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mw_alu_sequencer.md
# mw_alu_sequencer

Multi-word ALU sequencer for the basic computer datapath. It accepts one command naming an ALU operation and an operand length in words. It then streams operand word pairs through the shared 16-bit ALU one word at a time, chaining the E bit from each word's carry/shift-out into the next word. It emits the result words on an output stream and reports final E/Z/N/OVF flags. This lets the machine perform 32-, 48- and 64-bit add/logic/shift operations.

## Interface
- WIDTH, 16, ALU word width
- LEN_W, 4, width of word-count field (max 2^LEN_W-1 words)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  ALU encoding: 001 ADD, 010 AND, 011 TRANSFER, 100 COMPLEMENT, 101 SHR, 110 SHL
- cmd_len  in  LEN_W  number of words
- cmd_cin  in  1  initial E (carry-in / shift-in)
- in_valid, in_ready  in/out  1  operand word handshake
- in_a, in_b  in  WIDTH  AC-side and DR-side operand word
- alu_ac, alu_dr  out  WIDTH  drive ALU AC/DR
- alu_e  out  1  drive ALU E
- alu_op  out  3  drive ALU op_select
- alu_result  in  WIDTH; alu_co, alu_ovf  in  1  ALU outputs
- out_valid, out_ready  out/in  1  result word handshake
- out_word  out  WIDTH  result word
- out_last  out  1  marks final word
- done  out  1  one-cycle completion pulse
- flag_e, flag_z, flag_n, flag_ovf, flag_err  out  1  final status
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, FETCH, EXEC, EMIT, DONE.
- IDLE:
  - cmd_valid&cmd_ready latches op, len, and E<=cmd_cin; clears the Z accumulator.
  - Illegal op (000/111) or len=0 -> DONE with flag_err=1, flag_e=cmd_cin, other flags 0.
  - Otherwise -> FETCH with flag_err=0.
- FETCH: in_ready=1; on in_valid, latch in_a/in_b -> EXEC.
- EXEC: alu_ac=a_reg, alu_dr=b_reg, alu_e=E, alu_op=op_reg. Capture at the clock edge:
  - out_word<=alu_result.
  - ADD/SHR/SHL: E<=alu_co. AND/TRANSFER/COMPLEMENT: E unchanged (ALU CO ignored).
  - z_acc<=z_acc & (alu_result==0).
  - ovf_reg<=alu_ovf for ADD, else 0.
  - Next state: EMIT.
- EMIT: out_valid=1, out_last=(remaining==1). On out_ready: decrement remaining; -> DONE if last, else FETCH.
- DONE: done=1 for exactly one cycle, then -> IDLE. At DONE entry the flags load as:
  - flag_e=E.
  - flag_z=z_acc.
  - flag_n=MSB of last out_word.
  - flag_ovf=ovf_reg.
- Word order is the processing order:
  - LSW first for ADD/AND/TRANSFER/COMPLEMENT/SHL.
  - MSW first for SHR, so the shifted-out bit feeds the next lower word.
- alu_op=000 outside EXEC (the ALU holds its previous result). alu_ac/alu_dr/alu_e are always driven from the registers.
- in_a is ignored by TRANSFER; in_b is ignored by COMPLEMENT/SHR/SHL. A word pair is still consumed in each case.

## Timing
- Reset: state IDLE. All outputs 0, including cmd_ready, which rises the first cycle after rst_n=1. E, counters and flags are all 0.
- Reset mid-operation: aborts immediately. No done pulse; partial output is discarded; flags are cleared.
- Per word: FETCH handshake edge -> EXEC (1 cycle) -> out_valid asserted the next cycle. With no stalls, a word takes 3 cycles (FETCH, EXEC, EMIT).
- Full command latency with no stalls: 1 (accept) + 3·len + 1 (DONE) cycles.
- in_ready and out_valid are never high together. While out_valid=1 and out_ready=0, out_word and out_last hold stable.
- Flags are valid from the done cycle until the next command is accepted; they are unchanged otherwise.
- cmd_valid during busy is ignored, not queued.
- The len counter has no wrap: at most 2^LEN_W-1 words.

## Test plan
- ADD, len=2, cin=0, a={FFFF,0001}, b={0001,0000} -> out={0000,0002}. E=1 between the words; flag_e=0, z=0, n=0, ovf=0; done at cycle 8 after accept.
- ADD, len=1, a=7FFF, b=0001 -> out=8000, flag_ovf=1, flag_n=1, flag_e=0.
- SHL, len=2, cin=1, a={8000,0001} -> out={0001,0003}, flag_e=0. SHR, len=2, cin=0, a (MSW first)={0001,0000} -> out={0000,8000}, flag_n=1, flag_e=0.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT -> out_word stable, in_ready=0, no extra word consumed, done delayed by 5.
- cmd_op=111 (and separately cmd_len=0) -> done the cycle after accept, flag_err=1, no in_ready pulse.
- rst_n=0 during word 2 of a 3-word AND -> next cycle all outputs 0, no done; cmd_ready=1 the cycle after release. A new 1-word AND 00FF&0F0F -> 000F, flag_z=0.
